// File: rtl/dmw_buf_if.sv
// dmw_buf_if -- store-buffer bus bundle between the MEM stage, the store
// buffer and data memory.
//
// Signals:
//   st_valid/st_op/st_addr/st_data  store request from the MEM stage
//   st_ready, st_misalign           buffer back-pressure and misalign flag
//   dm_req/dm_addr/dm_wd/dm_be      head-entry write request to data memory
//   dm_ack                          data memory accepted the head entry
//   ld_addr, ld_conflict            load hazard probe
//   empty                           buffer holds no valid entries
//
// Modports:
//   master  the pipeline/memory side that drives requests and acks
//   slave   the store buffer itself
interface dmw_buf_if;
  logic        st_valid;
  logic [5:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        st_misalign;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        empty;

  modport master (
    output st_valid, st_op, st_addr, st_data, dm_ack, ld_addr,
    input  st_ready, st_misalign, dm_req, dm_addr, dm_wd, dm_be,
           ld_conflict, empty
  );

  modport slave (
    input  st_valid, st_op, st_addr, st_data, dm_ack, ld_addr,
    output st_ready, st_misalign, dm_req, dm_addr, dm_wd, dm_be,
           ld_conflict, empty
  );
endinterface

// File: rtl/dmw_buf.sv
// dmw_buf -- data-memory write (store) buffer.
//
// Stores leaving the MEM stage are decoded (SB/SH/SW), lane-aligned and
// queued in a DEPTH-entry circular FIFO. The head entry is presented to data
// memory on dm_req and popped on dm_ack, so memory writes leave in program
// order. Loads probe the buffer through ld_addr/ld_conflict.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   dmw_buf_if.slave (store request, memory write, load probe, empty)
//
// Parameters:
//   DEPTH  entry count, power of two, >= 2
//
// Optional feature:
//   STORE_MERGE_EN  when defined, a store to the same word as the youngest
//                   entry is folded into it, provided that entry is not the
//                   one currently presented to memory.
module dmw_buf #(
  parameter int DEPTH = 4
) (
  input logic      clk,
  input logic      rst,
  dmw_buf_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // MIPS primary opcodes for the three store flavours.
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      wd_q   [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic             misalign_q;

  logic        is_store;
  logic        misaligned;
  logic [3:0]  new_be;
  logic [31:0] new_wd;
  logic        cand;
  logic        enq;
  logic        pop;
  logic        merge;
  logic [PW-1:0] last;
  logic [3:0]  merged_be;
  logic [31:0] merged_wd;
  logic        unused_ld_lo;

  // Decode the incoming store: byte enables follow the low address bits and
  // the data is replicated across lanes so memory can pick whichever lane the
  // enables select. Non-store opcodes leave is_store low and are ignored.
  always_comb begin
    is_store   = 1'b0;
    misaligned = 1'b0;
    new_be     = 4'b0000;
    new_wd     = bus.st_data;
    if (bus.st_op == OP_SB) begin
      is_store = 1'b1;
      new_be   = 4'b0001 << bus.st_addr[1:0];
      new_wd   = {4{bus.st_data[7:0]}};
    end else if (bus.st_op == OP_SH) begin
      is_store   = 1'b1;
      misaligned = bus.st_addr[0];
      new_be     = bus.st_addr[1] ? 4'b1100 : 4'b0011;
      new_wd     = {2{bus.st_data[15:0]}};
    end else if (bus.st_op == OP_SW) begin
      is_store   = 1'b1;
      misaligned = |bus.st_addr[1:0];
      new_be     = 4'b1111;
      new_wd     = bus.st_data;
    end
  end

  // A full buffer refuses stores even when the head pops in the same cycle,
  // which keeps st_ready independent of dm_ack.
  assign bus.st_ready = (count_q != FULL);
  assign cand         = bus.st_valid & bus.st_ready & is_store;
  assign enq          = cand & ~misaligned;
  assign pop          = bus.dm_req & bus.dm_ack;

`ifdef STORE_MERGE_EN
  // The youngest entry sits one slot behind the tail. With a single entry it
  // is also the head being offered to memory, so merging is only allowed
  // once at least two entries are queued.
  assign last  = tail_q - PW'(1);
  assign merge = enq && (count_q > CW'(1)) &&
                 (addr_q[last] == bus.st_addr[31:2]);

  // Fold the new store into the youngest entry lane by lane: enabled lanes
  // take the new bytes, the rest keep what was there.
  always_comb begin
    merged_be = be_q[last] | new_be;
    merged_wd = wd_q[last];
    for (int l = 0; l < 4; l++) begin
      if (new_be[l]) merged_wd[8*l +: 8] = new_wd[8*l +: 8];
    end
  end
`else
  assign last      = tail_q;
  assign merge     = 1'b0;
  assign merged_be = new_be;
  assign merged_wd = new_wd;
`endif

  // FIFO state: pointers wrap naturally because DEPTH is a power of two.
  // A push and a pop in the same cycle never touch the same slot, since the
  // buffer is then neither empty nor full. Reset discards every entry,
  // including one that memory may be half-way through accepting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      misalign_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        wd_q[i]   <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      misalign_q <= cand & misaligned;
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (merge) begin
        be_q[last] <= merged_be;
        wd_q[last] <= merged_wd;
      end else if (enq) begin
        addr_q[tail_q]  <= bus.st_addr[31:2];
        wd_q[tail_q]    <= new_wd;
        be_q[tail_q]    <= new_be;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      count_q <= count_q + CW'(enq & ~merge) - CW'(pop);
    end
  end

  // The head entry is driven straight from storage, so it cannot change
  // while memory stalls. Outputs read as zero when nothing is queued.
  assign bus.dm_req      = (count_q != '0);
  assign bus.dm_addr     = bus.dm_req ? {addr_q[head_q], 2'b00} : 32'h0;
  assign bus.dm_wd       = bus.dm_req ? wd_q[head_q] : 32'h0;
  assign bus.dm_be       = bus.dm_req ? be_q[head_q] : 4'b0000;
  assign bus.st_misalign = misalign_q;
  assign bus.empty       = ~|valid_q;

  // Load hazard probe: word-granular match against every live entry.
  always_comb begin
    bus.ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == bus.ld_addr[31:2])) bus.ld_conflict = 1'b1;
    end
  end

  assign unused_ld_lo = ^bus.ld_addr[1:0];

endmodule

// File: tb/tb_dmw_buf.sv
// tb_dmw_buf -- directed self-checking bench for dmw_buf (DEPTH = 4).
//
// Each scenario task drives its stimulus and compares outputs against
// hand-computed values. Inputs change 1 ns after a rising edge; outputs are
// sampled at that point or after a further 1 ns for combinational paths.
module tb_dmw_buf;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_LW = 6'b100011;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  dmw_buf_if bus ();

  dmw_buf #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] data);
    bus.st_valid = 1'b1;
    bus.st_op    = op;
    bus.st_addr  = addr;
    bus.st_data  = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.dm_ack  = 1'b0;
    bus.ld_addr = 32'h40;
    drive_store(OP_SW, 32'h40, 32'h55);
    step();
    step();
    vectors++; if (bus.st_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_ready: got %b want 1", bus.st_ready); end
    vectors++; if (bus.dm_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_req: got %b want 0", bus.dm_req); end
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_empty: got %b want 1", bus.empty); end
    vectors++; if (bus.st_misalign !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_misalign: got %b want 0", bus.st_misalign); end
    vectors++; if (bus.ld_conflict !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_conflict: got %b want 0", bus.ld_conflict); end
    vectors++; if (bus.dm_be !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_be: got %b want 0000", bus.dm_be); end
    bus.st_valid = 1'b0;
    rst = 1'b0;
    step();
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_no_capture: got empty=%b want 1", bus.empty); end
  endtask

  task automatic test_sb_sh();
    bus.dm_ack = 1'b1;
    drive_store(OP_SB, 32'h103, 32'h0000_00AB);
    #1;
    vectors++; if (bus.dm_req !== 1'b0) begin miscompares++; $display("[TB] FAIL no_bypass: got %b want 0", bus.dm_req); end
    step();
    bus.st_valid = 1'b0;
    vectors++; if (bus.dm_req !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_req: got %b want 1", bus.dm_req); end
    vectors++; if (bus.dm_addr !== 32'h100) begin miscompares++; $display("[TB] FAIL sb_addr: got %h want 00000100", bus.dm_addr); end
    vectors++; if (bus.dm_be !== 4'b1000) begin miscompares++; $display("[TB] FAIL sb_be: got %b want 1000", bus.dm_be); end
    vectors++; if (bus.dm_wd !== 32'hABAB_ABAB) begin miscompares++; $display("[TB] FAIL sb_wd: got %h want ababab", bus.dm_wd); end
    step();
    vectors++; if (bus.dm_req !== 1'b0) begin miscompares++; $display("[TB] FAIL sb_one_cycle: got %b want 0", bus.dm_req); end
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_empty: got %b want 1", bus.empty); end
    drive_store(OP_SH, 32'h206, 32'h1234_BEEF);
    step();
    bus.st_valid = 1'b0;
    vectors++; if (bus.dm_addr !== 32'h204) begin miscompares++; $display("[TB] FAIL sh_addr: got %h want 00000204", bus.dm_addr); end
    vectors++; if (bus.dm_be !== 4'b1100) begin miscompares++; $display("[TB] FAIL sh_be: got %b want 1100", bus.dm_be); end
    vectors++; if (bus.dm_wd !== 32'hBEEF_BEEF) begin miscompares++; $display("[TB] FAIL sh_wd: got %h want beefbeef", bus.dm_wd); end
    step();
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL sh_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_misalign();
    bus.dm_ack = 1'b0;
    drive_store(OP_SH, 32'h201, 32'h0000_1234);
    step();
    bus.st_valid = 1'b0;
    vectors++; if (bus.st_misalign !== 1'b1) begin miscompares++; $display("[TB] FAIL sh_mis_flag: got %b want 1", bus.st_misalign); end
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL sh_mis_empty: got %b want 1", bus.empty); end
    step();
    vectors++; if (bus.st_misalign !== 1'b0) begin miscompares++; $display("[TB] FAIL sh_mis_pulse: got %b want 0", bus.st_misalign); end
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL sh_mis_empty2: got %b want 1", bus.empty); end
    drive_store(OP_SW, 32'h302, 32'h1);
    step();
    bus.st_valid = 1'b0;
    vectors++; if (bus.st_misalign !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_mis_flag: got %b want 1", bus.st_misalign); end
    drive_store(OP_LW, 32'h301, 32'h1);
    step();
    bus.st_valid = 1'b0;
    vectors++; if (bus.st_misalign !== 1'b0) begin miscompares++; $display("[TB] FAIL nonstore_flag: got %b want 0", bus.st_misalign); end
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL nonstore_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_full();
    bus.dm_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_store(OP_SW, 32'h1000 + 32'(4 * i), 32'hD000_0000 + 32'(i));
      #1;
      vectors++; if (bus.st_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_ready[%0d]: got %b want 1", i, bus.st_ready); end
      step();
    end
    drive_store(OP_SW, 32'h1010, 32'hD000_0004);
    #1;
    vectors++; if (bus.st_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready: got %b want 0", bus.st_ready); end
    step();
    vectors++; if (bus.dm_addr !== 32'h1000) begin miscompares++; $display("[TB] FAIL stall_addr: got %h want 00001000", bus.dm_addr); end
    vectors++; if (bus.dm_wd !== 32'hD000_0000) begin miscompares++; $display("[TB] FAIL stall_wd: got %h want d0000000", bus.dm_wd); end
    bus.dm_ack = 1'b1;
    drive_store(OP_SW, 32'h2000, 32'hEEEE_EEEE);
    step();
    bus.st_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      vectors++; if (bus.dm_addr !== 32'h1000 + 32'(4 * i)) begin miscompares++; $display("[TB] FAIL drain_addr[%0d]: got %h want %h", i, bus.dm_addr, 32'h1000 + 32'(4 * i)); end
      vectors++; if (bus.dm_wd !== 32'hD000_0000 + 32'(i)) begin miscompares++; $display("[TB] FAIL drain_wd[%0d]: got %h want %h", i, bus.dm_wd, 32'hD000_0000 + 32'(i)); end
      step();
    end
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_empty: got %b want 1", bus.empty); end
    vectors++; if (bus.dm_req !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_req: got %b want 0", bus.dm_req); end
  endtask

  task automatic test_back_to_back();
    bus.dm_ack = 1'b1;
    drive_store(OP_SW, 32'h800, 32'h1);
    step();
    drive_store(OP_SW, 32'h804, 32'h2);
    vectors++; if (bus.dm_addr !== 32'h800) begin miscompares++; $display("[TB] FAIL b2b_a: got %h want 00000800", bus.dm_addr); end
    step();
    drive_store(OP_SW, 32'h808, 32'h3);
    vectors++; if (bus.dm_addr !== 32'h804) begin miscompares++; $display("[TB] FAIL b2b_b_addr: got %h want 00000804", bus.dm_addr); end
    vectors++; if (bus.dm_wd !== 32'h2) begin miscompares++; $display("[TB] FAIL b2b_b_wd: got %h want 00000002", bus.dm_wd); end
    step();
    bus.st_valid = 1'b0;
    vectors++; if (bus.dm_addr !== 32'h808) begin miscompares++; $display("[TB] FAIL b2b_c: got %h want 00000808", bus.dm_addr); end
    step();
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_conflict();
    bus.dm_ack = 1'b0;
    drive_store(OP_SW, 32'h500, 32'hA);
    step();
    drive_store(OP_SW, 32'h504, 32'hB);
    step();
    bus.st_valid = 1'b0;
    bus.ld_addr  = 32'h506;
    #1;
    vectors++; if (bus.ld_conflict !== 1'b1) begin miscompares++; $display("[TB] FAIL conf_hit: got %b want 1", bus.ld_conflict); end
    bus.ld_addr = 32'h508;
    #1;
    vectors++; if (bus.ld_conflict !== 1'b0) begin miscompares++; $display("[TB] FAIL conf_miss: got %b want 0", bus.ld_conflict); end
    bus.ld_addr = 32'h506;
    bus.dm_ack  = 1'b1;
    step();
    vectors++; if (bus.ld_conflict !== 1'b1) begin miscompares++; $display("[TB] FAIL conf_after_first: got %b want 1", bus.ld_conflict); end
    step();
    vectors++; if (bus.ld_conflict !== 1'b0) begin miscompares++; $display("[TB] FAIL conf_after_pop: got %b want 0", bus.ld_conflict); end
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL conf_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_merge();
    bus.dm_ack = 1'b0;
    drive_store(OP_SW, 32'h600, 32'hCAFE_F00D);
    step();
    drive_store(OP_SB, 32'h304, 32'h11);
    step();
    drive_store(OP_SB, 32'h305, 32'h22);
    step();
    bus.st_valid = 1'b0;
    bus.dm_ack   = 1'b1;
    vectors++; if (bus.dm_addr !== 32'h600) begin miscompares++; $display("[TB] FAIL mrg_head: got %h want 00000600", bus.dm_addr); end
    step();
    vectors++; if (bus.dm_addr !== 32'h304) begin miscompares++; $display("[TB] FAIL mrg_addr: got %h want 00000304", bus.dm_addr); end
`ifdef STORE_MERGE_EN
    vectors++; if (bus.dm_be !== 4'b0011) begin miscompares++; $display("[TB] FAIL mrg_be: got %b want 0011", bus.dm_be); end
    vectors++; if (bus.dm_wd !== 32'h1111_2211) begin miscompares++; $display("[TB] FAIL mrg_wd: got %h want 11112211", bus.dm_wd); end
    step();
`else
    vectors++; if (bus.dm_be !== 4'b0001) begin miscompares++; $display("[TB] FAIL nomrg_be1: got %b want 0001", bus.dm_be); end
    vectors++; if (bus.dm_wd !== 32'h1111_1111) begin miscompares++; $display("[TB] FAIL nomrg_wd1: got %h want 11111111", bus.dm_wd); end
    step();
    vectors++; if (bus.dm_be !== 4'b0010) begin miscompares++; $display("[TB] FAIL nomrg_be2: got %b want 0010", bus.dm_be); end
    vectors++; if (bus.dm_wd !== 32'h2222_2222) begin miscompares++; $display("[TB] FAIL nomrg_wd2: got %h want 22222222", bus.dm_wd); end
    step();
`endif
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL mrg_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_reset_mid();
    bus.dm_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_store(OP_SW, 32'h700 + 32'(4 * i), 32'h77);
      step();
    end
    bus.st_valid = 1'b0;
    vectors++; if (bus.dm_req !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_req_before: got %b want 1", bus.dm_req); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (bus.dm_req !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_req: got %b want 0", bus.dm_req); end
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_empty: got %b want 1", bus.empty); end
    vectors++; if (bus.st_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_ready: got %b want 1", bus.st_ready); end
    vectors++; if (bus.dm_be !== 4'b0000) begin miscompares++; $display("[TB] FAIL mid_be: got %b want 0000", bus.dm_be); end
    #1;
    rst = 1'b0;
    step();
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_after: got %b want 1", bus.empty); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst          = 1'b1;
    bus.st_valid = 1'b0;
    bus.st_op    = 6'b0;
    bus.st_addr  = 32'h0;
    bus.st_data  = 32'h0;
    bus.dm_ack   = 1'b0;
    bus.ld_addr  = 32'h0;
    test_reset();
    test_sb_sh();
    test_misalign();
    test_full();
    test_back_to_back();
    test_conflict();
    test_merge();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmw_buf.md
DMW_BUF -- requirements
Module: dmw_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, store-buffer entry count (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port st_valid  input  1  store request from MEM stage.
REQ-005 SHALL have port st_op  input  6  instr[31:26]; decoded with instr_def.v macros OP_SB, OP_SH, OP_SW.
REQ-006 SHALL have port st_addr  input  32  byte address (alu_result).
REQ-007 SHALL have port st_data  input  32  rt register value.
REQ-008 SHALL have port st_ready  output  1  buffer can accept a store this cycle.
REQ-009 SHALL have port st_misalign  output  1  one-cycle registered misaligned-store flag.
REQ-010 SHALL have port dm_req  output  1  write request to data memory.
REQ-011 SHALL have port dm_addr  output  32  word address, bits[1:0]=00.
REQ-012 SHALL have port dm_wd  output  32  lane-aligned write data.
REQ-013 SHALL have port dm_be  output  4  byte enables, bit i = byte lane i (bits 8i+7:8i).
REQ-014 SHALL have port dm_ack  input  1  memory accepted the head entry.
REQ-015 SHALL have port ld_addr  input  32  load address for hazard check.
REQ-016 SHALL have port ld_conflict  output  1  some valid entry matches ld_addr[31:2].
REQ-017 SHALL have port empty  output  1  no valid entries.

Function
REQ-018 SHALL accept (enqueue) a store when st_valid & st_ready & st_op in {SB,SH,SW} & aligned; other st_op values ignored with no state change.
REQ-019 SHALL form SB: be = 4'b0001 << st_addr[1:0], wd = {4{st_data[7:0]}}.
REQ-020 SHALL form SH: be = st_addr[1] ? 4'b1100 : 4'b0011, wd = {2{st_data[15:0]}}; st_addr[0]=1 is misaligned.
REQ-021 SHALL form SW: be = 4'b1111, wd = st_data; st_addr[1:0]!=00 is misaligned.
REQ-022 SHALL, on a misaligned accepted-candidate store, not enqueue and drive st_misalign=1 for exactly the next cycle.
REQ-023 SHALL implement a DEPTH-entry circular FIFO with head/tail pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-024 SHALL drive st_ready = (count != DEPTH); no enqueue while full, even if the head pops that cycle.
REQ-025 SHALL drive dm_req = (count != 0), with dm_addr/dm_wd/dm_be taken from the head entry.
REQ-026 SHALL hold dm_addr/dm_wd/dm_be stable while dm_req=1 and dm_ack=0.
REQ-027 SHALL pop the head on a rising edge where dm_req & dm_ack; dm_ack while dm_req=0 is ignored.
REQ-028 SHALL allow simultaneous enqueue and pop; count unchanged, both pointers advance.
REQ-029 SHALL make an entry enqueued at edge N visible on dm_req no earlier than cycle after edge N (no bypass).
REQ-030 SHALL preserve program order of memory writes.
REQ-031 SHALL compute ld_conflict and empty combinationally from current valid entries only.

Reset
REQ-032 SHALL, on rst=1 (any time, incl. mid-handshake), clear count and pointers, discard all entries, and force st_ready=1, dm_req=0, st_misalign=0, empty=1, ld_conflict=0, dm_be=0.
REQ-033 SHALL accept no store in the cycle rst is asserted.

Configuration
REQ-034 SHALL, with STORE_MERGE_EN defined, merge an accepted store into the tail entry when word addresses match and the tail is not the head currently presented on dm_req: tail be |= new be, enabled lanes overwritten with new data, count unchanged.
REQ-035 SHALL, without STORE_MERGE_EN, always enqueue accepted stores as new entries.

Verification
REQ-036 SHALL cover: SB addr 0x103, data 0x000000AB, dm_ack=1 -> one dm_req cycle, dm_addr 0x100, dm_be 1000, dm_wd 0xABABABAB.
REQ-037 SHALL cover: SH addr 0x201 -> no enqueue, st_misalign=1 for one cycle, empty stays 1.
REQ-038 SHALL cover: dm_ack=0, DEPTH+1 SW stores -> st_ready=0 after DEPTH, last store not taken; then dm_ack=1 drains in order.
REQ-039 SHALL cover: stores queued, ld_addr matches second entry word -> ld_conflict=1; after it pops -> 0.
REQ-040 SHALL cover: STORE_MERGE_EN, head stalled, SB 0x304 data 0x11 then SB 0x305 data 0x22 -> single entry be 0011, wd[15:0]=0x2211.
REQ-041 SHALL cover: rst pulse while dm_req=1, dm_ack=0, count=3 -> dm_req=0, empty=1 immediately.
